seller_ctrl: RTL and testbench



---
 rtl/seller_pkg.sv | 30 +++
 rtl/seller_change_gen.sv | 62 ++++++
 rtl/seller_ctrl.sv | 151 +++++++++++++++
 tb/tb_seller_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seller_pkg.sv
// ----------------------------------------------------------------------------
// seller_pkg
// Shared definitions for the seller vending-machine controller:
//   - state_t    : transaction FSM state encoding
//   - HALF_VAL   : credit value of the 0.5-unit coin key (in half-units)
//   - ONE_VAL    : credit value of the 1-unit coin key (in half-units)
//   - coin_sum() : half-unit value of the coin pulses seen in one cycle (0..3)
// ----------------------------------------------------------------------------
package seller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        REFUND  = 2'd3
    } state_t;

    localparam int HALF_VAL = 1;
    localparam int ONE_VAL  = 2;

    // Both keys may pulse in the same cycle; their values simply add.
    function automatic logic [1:0] coin_sum(input logic half, input logic one);
        logic [1:0] s;
        s = 2'd0;
        if (half) s = s + 2'(HALF_VAL);
        if (one)  s = s + 2'(ONE_VAL);
        return s;
    endfunction

endpackage

// File: rtl/seller_change_gen.sv
// ----------------------------------------------------------------------------
// seller_change_gen
// Emits a paced train of half-unit change pulses. A start strobe loads the
// number of pulses; the first pulse is visible in the cycle right after the
// strobe edge, each further pulse GAP cycles after the previous one.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   start       in   load strobe (load_val must be non-zero)
//   load_val    in   number of half-unit pulses to emit
//   change_half out  registered 1-cycle pulse per half-unit
//   done        out  high during the last pulse of the train
// ----------------------------------------------------------------------------
module seller_change_gen #(
    parameter int CREDIT_W = 4,
    parameter int GAP      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CREDIT_W-1:0] load_val,
    output logic                change_half,
    output logic                done
);

    localparam int GAP_W = (GAP > 2) ? $clog2(GAP) : 1;

    // Pulses still owed after the one currently on change_half.
    logic [CREDIT_W-1:0] remain;
    logic [GAP_W-1:0]    gap_cnt;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; blocking assignments would create
    // order-dependent simulation and mismatch synthesis.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain      <= '0;
            gap_cnt     <= '0;
            change_half <= 1'b0;
        end else if (start) begin
            change_half <= 1'b1;
            remain      <= load_val - CREDIT_W'(1);
            gap_cnt     <= GAP_W'(GAP - 1);
        end else if (remain != '0) begin
            if (gap_cnt == '0) begin
                change_half <= 1'b1;
                remain      <= remain - CREDIT_W'(1);
                gap_cnt     <= GAP_W'(GAP - 1);
            end else begin
                change_half <= 1'b0;
                gap_cnt     <= gap_cnt - GAP_W'(1);
            end
        end else begin
            change_half <= 1'b0;
        end
    end

    // The owner can leave its refund state on the edge that ends this pulse.
    assign done = change_half && (remain == '0);

endmodule

// File: rtl/seller_ctrl.sv
// ----------------------------------------------------------------------------
// seller_ctrl
// Vending-machine transaction controller. Accumulates coin credit from the
// debounced key pulses, issues a one-cycle vend pulse once PRICE is reached,
// and returns change / refunds as GAP-spaced half-unit pulses.
//
// Optional feature: define SELLER_TIMEOUT_EN to auto-refund after TIMEOUT
// coin-free cycles in COLLECT. Without it COLLECT waits indefinitely.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   coin_half_flag in   1-cycle pulse, +1 half-unit
//   coin_one_flag  in   1-cycle pulse, +2 half-units
//   cancel_flag    in   1-cycle pulse, abort and refund
//   goods          out  1-cycle vend pulse
//   change_half    out  1-cycle pulse per half-unit returned
//   coin_reject    out  1-cycle pulse: coin arrived while busy
//   credit         out  current accumulated credit (half-units)
//   busy           out  high while in VEND or REFUND
// ----------------------------------------------------------------------------
module seller_ctrl
    import seller_pkg::*;
#(
    parameter int PRICE    = 5,
    parameter int CREDIT_W = 4,
    parameter int GAP      = 4,
    parameter int TIMEOUT  = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_half_flag,
    input  logic                coin_one_flag,
    input  logic                cancel_flag,
    output logic                goods,
    output logic                change_half,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam logic [CREDIT_W:0] PRICE_EXT = (CREDIT_W+1)'(PRICE);

    state_t              state;
    logic [CREDIT_W-1:0] chg_cnt;

    logic [1:0]          sum;
    logic [CREDIT_W:0]   next_credit;   // one extra bit: credit+3 may pass 2^CREDIT_W-1
    logic                vend_now;
    logic                refund_now;
    logic                start;
    logic [CREDIT_W-1:0] load_val;
    logic                coin_any;
    logic                timeout_hit;
    logic                done;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        sum         = coin_sum(coin_half_flag, coin_one_flag);
        next_credit = {1'b0, credit} + (CREDIT_W+1)'(sum);
        coin_any    = coin_half_flag | coin_one_flag;
        vend_now    = 1'b0;
        refund_now  = 1'b0;
        if (state == IDLE || state == COLLECT) begin
            vend_now = (next_credit >= PRICE_EXT);
        end
        // Same-cycle coins reaching PRICE win over cancel/timeout.
        if (state == COLLECT && !vend_now) begin
            refund_now = cancel_flag | timeout_hit;
        end
        start    = refund_now | ((state == VEND) && (chg_cnt != '0));
        load_val = (state == VEND) ? chg_cnt : next_credit[CREDIT_W-1:0];
    end

`ifdef SELLER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts coin-free COLLECT cycles; the TIMEOUT-th one triggers the refund.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state != COLLECT || coin_any || timeout_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign timeout_hit = (state == COLLECT) && !coin_any &&
                         (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            credit      <= '0;
            chg_cnt     <= '0;
            goods       <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            goods       <= 1'b0;
            coin_reject <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    if (vend_now) begin
                        state   <= VEND;
                        goods   <= 1'b1;
                        credit  <= '0;
                        chg_cnt <= CREDIT_W'(next_credit - PRICE_EXT);
                    end else if (refund_now) begin
                        state   <= REFUND;
                        credit  <= '0;
                        chg_cnt <= next_credit[CREDIT_W-1:0];
                    end else if (sum != 2'd0) begin
                        state   <= COLLECT;
                        credit  <= next_credit[CREDIT_W-1:0];
                    end
                end
                VEND: begin
                    coin_reject <= coin_any;
                    state       <= (chg_cnt != '0) ? REFUND : IDLE;
                end
                REFUND: begin
                    coin_reject <= coin_any;
                    if (change_half) chg_cnt <= chg_cnt - CREDIT_W'(1);
                    if (done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == VEND) || (state == REFUND);

    seller_change_gen #(
        .CREDIT_W (CREDIT_W),
        .GAP      (GAP)
    ) u_change_gen (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .load_val    (load_val),
        .change_half (change_half),
        .done        (done)
    );

endmodule

// File: tb/tb_seller_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seller_ctrl
// Directed self-checking bench for seller_ctrl (PRICE=5, GAP=4, TIMEOUT=20).
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_seller_ctrl;

    localparam int PRICE    = 5;
    localparam int CREDIT_W = 4;
    localparam int GAP      = 4;
    localparam int TIMEOUT  = 20;

    logic                clk;
    logic                rst;
    logic                coin_half_flag;
    logic                coin_one_flag;
    logic                cancel_flag;
    logic                goods;
    logic                change_half;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    int n_checks;
    int n_fail;

    // Pulse bookkeeping gathered on every falling edge outside reset.
    int      goods_cnt;
    int      chg_cnt;
    int      busy_cnt;
    int      rej_cnt;
    time     chg_times[$];
    time     t0;

    seller_ctrl #(
        .PRICE    (PRICE),
        .CREDIT_W (CREDIT_W),
        .GAP      (GAP),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .coin_half_flag (coin_half_flag),
        .coin_one_flag  (coin_one_flag),
        .cancel_flag    (cancel_flag),
        .goods          (goods),
        .change_half    (change_half),
        .coin_reject    (coin_reject),
        .credit         (credit),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (goods)       goods_cnt++;
            if (busy)        busy_cnt++;
            if (coin_reject) rej_cnt++;
            if (change_half) begin
                chg_cnt++;
                chg_times.push_back($time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        goods_cnt = 0;
        chg_cnt   = 0;
        busy_cnt  = 0;
        rej_cnt   = 0;
        chg_times.delete();
    endtask

    // Called at a falling edge: hold the flags for one rising edge, then
    // return at the next falling edge where the registered response is visible.
    task automatic drive(input logic h, input logic o, input logic c);
        coin_half_flag = h;
        coin_one_flag  = o;
        cancel_flag    = c;
        @(negedge clk);
        coin_half_flag = 1'b0;
        coin_one_flag  = 1'b0;
        cancel_flag    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        coin_half_flag = 1'b0;
        coin_one_flag  = 1'b0;
        cancel_flag    = 1'b0;
        clear_counts();

        // Reset state
        idle(2);
        check("rst_goods",  32'(goods), 0);
        check("rst_change", 32'(change_half), 0);
        check("rst_reject", 32'(coin_reject), 0);
        check("rst_credit", 32'(credit), 0);
        check("rst_busy",   32'(busy), 0);
        rst = 1'b0;
        idle(2);

        // 1) 2 + 2 + 1 = 5: exact price, no change
        clear_counts();
        drive(0, 1, 0);
        check("t1_credit2", 32'(credit), 2);
        check("t1_busy0",   32'(busy), 0);
        drive(0, 1, 0);
        check("t1_credit4", 32'(credit), 4);
        drive(1, 0, 0);
        check("t1_goods",   32'(goods), 1);
        check("t1_credit0", 32'(credit), 0);
        check("t1_busy1",   32'(busy), 1);
        idle(10);
        check("t1_goods_cnt", 32'(goods_cnt), 1);
        check("t1_chg_cnt",   32'(chg_cnt), 0);
        check("t1_busy_cnt",  32'(busy_cnt), 1);

        // 2) 2 + 2 + 2 = 6: vend plus one half-unit of change right after goods
        clear_counts();
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        check("t2_goods", 32'(goods), 1);
        check("t2_no_chg_in_vend", 32'(change_half), 0);
        idle(1);
        check("t2_chg_after_goods", 32'(change_half), 1);
        check("t2_goods_gone", 32'(goods), 0);
        idle(10);
        check("t2_goods_cnt", 32'(goods_cnt), 1);
        check("t2_chg_cnt",   32'(chg_cnt), 1);
        check("t2_busy_cnt",  32'(busy_cnt), 2);
        check("t2_credit",    32'(credit), 0);

        // 3) half+one together (3), then one -> 5: vend, no change
        clear_counts();
        drive(1, 1, 0);
        check("t3_credit3", 32'(credit), 3);
        drive(0, 1, 0);
        check("t3_goods", 32'(goods), 1);
        idle(10);
        check("t3_chg_cnt", 32'(chg_cnt), 0);

        // 4) cancel in IDLE is ignored
        clear_counts();
        drive(0, 0, 1);
        check("t4_idle_cancel_busy", 32'(busy), 0);
        idle(5);
        check("t4_idle_cancel_chg", 32'(chg_cnt), 0);

        // 5) coin_one, then cancel with coin_half: refund 3, GAP-spaced
        clear_counts();
        drive(0, 1, 0);
        drive(1, 0, 1);
        check("t5_first_chg", 32'(change_half), 1);
        check("t5_busy",      32'(busy), 1);
        check("t5_credit0",   32'(credit), 0);
        drive(0, 1, 0);
        check("t5_reject",        32'(coin_reject), 1);
        check("t5_reject_credit", 32'(credit), 0);
        idle(12);
        check("t5_chg_cnt",   32'(chg_cnt), 3);
        check("t5_goods_cnt", 32'(goods_cnt), 0);
        check("t5_rej_cnt",   32'(rej_cnt), 1);
        check("t5_busy_cnt",  32'(busy_cnt), 9);
        if (chg_times.size() == 3) begin
            check("t5_gap01", 32'((chg_times[1] - chg_times[0]) / 10), GAP);
            check("t5_gap12", 32'((chg_times[2] - chg_times[1]) / 10), GAP);
        end else begin
            check("t5_gap_pulses", 32'(chg_times.size()), 3);
        end

        // 6) vend priority: credit 4 + half with cancel -> goods, no refund
        clear_counts();
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(1, 0, 1);
        check("t6_goods", 32'(goods), 1);
        idle(10);
        check("t6_chg_cnt", 32'(chg_cnt), 0);

        // 7) reset in the middle of a 3-pulse refund, after the first pulse
        clear_counts();
        drive(1, 1, 0);
        drive(0, 0, 1);
        check("t7_first_chg", 32'(change_half), 1);
        idle(2);
        rst = 1'b1;
        #1;
        check("t7_rst_chg",    32'(change_half), 0);
        check("t7_rst_busy",   32'(busy), 0);
        check("t7_rst_credit", 32'(credit), 0);
        check("t7_rst_goods",  32'(goods), 0);
        @(negedge clk);
        rst = 1'b0;
        clear_counts();
        idle(12);
        check("t7_no_more_chg", 32'(chg_cnt), 0);
        check("t7_idle_busy",   32'(busy_cnt), 0);
        drive(1, 0, 0);
        check("t7_fresh_credit", 32'(credit), 1);
        drive(0, 0, 1);
        idle(3);

        // 8) idle COLLECT: auto-refund only when the timeout is built in
        clear_counts();
        drive(0, 1, 0);
        t0 = $time;
        idle(15);
        check("t8_no_early_chg", 32'(chg_cnt), 0);
        idle(85);
`ifdef SELLER_TIMEOUT_EN
        check("t8_tmo_chg_cnt", 32'(chg_cnt), 2);
        check("t8_tmo_credit",  32'(credit), 0);
        if (chg_times.size() == 2) begin
            check("t8_tmo_delay", 32'((chg_times[0] - t0) / 10), TIMEOUT);
            check("t8_tmo_gap",   32'((chg_times[1] - chg_times[0]) / 10), GAP);
        end else begin
            check("t8_tmo_pulses", 32'(chg_times.size()), 2);
        end
`else
        check("t8_wait_chg_cnt", 32'(chg_cnt), 0);
        check("t8_wait_credit",  32'(credit), 2);
        check("t8_wait_busy",    32'(busy), 0);
        drive(0, 0, 1);
        idle(6);
        check("t8_cancel_chg", 32'(chg_cnt), 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
